// File: rtl/ps2_game_pkg.sv
// Shared scan codes, entry-stage encoding and grid helpers for the PS/2 coordinate entry block.
package ps2_game_pkg;

  localparam int unsigned GRID_SIZE  = 9;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24,
                         SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43;
  localparam logic [7:0] SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25, SC_5 = 8'h2E,
                         SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46;
  localparam logic [7:0] SC_ENTER = 8'h5A, SC_BKSP = 8'h66, SC_ESC = 8'h76;
  localparam logic [7:0] SC_EXT   = 8'hE0, SC_BRK  = 8'hF0;

  typedef enum logic [1:0] {
    STAGE_LETTER  = 2'd0,
    STAGE_NUMBER  = 2'd1,
    STAGE_CONFIRM = 2'd2
  } stage_e;

  typedef logic [GRID_SIZE-1:0] coord_t;

  // Received byte as handed from the receiver to the decoder.
  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } rx_byte_t;

  function automatic coord_t letter_onehot(input logic [7:0] code);
    case (code)
      SC_A:    return coord_t'(9'b000000001);
      SC_B:    return coord_t'(9'b000000010);
      SC_C:    return coord_t'(9'b000000100);
      SC_D:    return coord_t'(9'b000001000);
      SC_E:    return coord_t'(9'b000010000);
      SC_F:    return coord_t'(9'b000100000);
      SC_G:    return coord_t'(9'b001000000);
      SC_H:    return coord_t'(9'b010000000);
      SC_I:    return coord_t'(9'b100000000);
      default: return '0;
    endcase
  endfunction

  function automatic coord_t number_onehot(input logic [7:0] code);
    case (code)
      SC_1:    return coord_t'(9'b000000001);
      SC_2:    return coord_t'(9'b000000010);
      SC_3:    return coord_t'(9'b000000100);
      SC_4:    return coord_t'(9'b000001000);
      SC_5:    return coord_t'(9'b000010000);
      SC_6:    return coord_t'(9'b000100000);
      SC_7:    return coord_t'(9'b001000000);
      SC_8:    return coord_t'(9'b010000000);
      SC_9:    return coord_t'(9'b100000000);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames on falling
// clock edges, checks start/parity/stop and aborts stalled frames after an idle timeout.
module ps2_rx
  import ps2_game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  output rx_byte_t rx,
  output logic     frame_err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic [3:0]             bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [IDLE_W-1:0]      idle_cnt;

  logic                  fall_c, frame_ok_c, timeout_c;
  logic [FRAME_BITS-1:0] frame_c;

  assign fall_c     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign frame_c    = {data_sync[SYNC_STAGES-1], shreg[FRAME_BITS-1:1]};
  assign frame_ok_c = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);
  // An edge in the same cycle always takes precedence over the idle limit.
  assign timeout_c  = ~fall_c && (bit_cnt != 4'd0) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
      idle_cnt  <= '0;
      rx        <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      rx.valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall_c) begin
        shreg    <= frame_c;
        idle_cnt <= '0;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          bit_cnt <= 4'd0;
          if (frame_ok_c) begin
            rx.valid <= 1'b1;
            rx.code  <= frame_c[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timeout_c) begin
        bit_cnt   <= 4'd0;
        idle_cnt  <= '0;
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_coord_entry.sv
// Keyboard coordinate entry: decodes set-2 make codes into a one-hot letter/number pair
// and commits it on Enter, with Backspace and Esc editing.
module ps2_coord_entry
  import ps2_game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                 clock27,
  input  logic                 reset_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [GRID_SIZE-1:0] letter,
  output logic [GRID_SIZE-1:0] number,
  output logic                 keyboard_data,
  output logic [1:0]           entry_stage,
  output logic                 frame_err
);

  rx_byte_t rx;
  stage_e   state, state_nxt;
  coord_t   letter_nxt, number_nxt;
  logic     kbd_nxt, ext_pend, brk_pend, ext_nxt, brk_nxt;
  coord_t   let_c, num_c;
  logic     key_c;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk      (clock27),
    .rst_n    (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx),
    .frame_err(frame_err)
  );

  assign let_c       = letter_onehot(rx.code);
  assign num_c       = number_onehot(rx.code);
  // A plain make code: not a prefix and not following a break/extended prefix.
  assign key_c       = rx.valid && !ext_pend && !brk_pend && (rx.code != SC_EXT) && (rx.code != SC_BRK);
  assign entry_stage = state;

  always_ff @(posedge clock27 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= STAGE_LETTER;
      letter        <= '0;
      number        <= '0;
      keyboard_data <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
    end else begin
      state         <= state_nxt;
      letter        <= letter_nxt;
      number        <= number_nxt;
      keyboard_data <= kbd_nxt;
      ext_pend      <= ext_nxt;
      brk_pend      <= brk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (keyboard_data) begin
      state_nxt = STAGE_LETTER;
    end else if (key_c) begin
      if (rx.code == SC_ESC) begin
        state_nxt = STAGE_LETTER;
      end else begin
        case (state)
          STAGE_LETTER:  if (|let_c) state_nxt = STAGE_NUMBER;
          STAGE_NUMBER: begin
            if (|num_c)                   state_nxt = STAGE_CONFIRM;
            else if (rx.code == SC_BKSP)  state_nxt = STAGE_LETTER;
          end
          STAGE_CONFIRM: if (rx.code == SC_BKSP) state_nxt = STAGE_NUMBER;
          default:       state_nxt = STAGE_LETTER;
        endcase
      end
    end
  end

  // Commit holds the coordinate through the strobe cycle; it is cleared on the next.
  always_comb begin
    letter_nxt = letter;
    number_nxt = number;
    kbd_nxt    = 1'b0;
    ext_nxt    = ext_pend;
    brk_nxt    = brk_pend;
    if (rx.valid) begin
      if (rx.code == SC_EXT)          ext_nxt = 1'b1;
      else if (rx.code == SC_BRK)     brk_nxt = 1'b1;
      else if (ext_pend || brk_pend) begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
      end
    end
    if (keyboard_data) begin
      letter_nxt = '0;
      number_nxt = '0;
    end else if (key_c) begin
      if (rx.code == SC_ESC) begin
        letter_nxt = '0;
        number_nxt = '0;
      end else begin
        case (state)
          STAGE_LETTER: if (|let_c) letter_nxt = let_c;
          STAGE_NUMBER: begin
            if (|num_c)                  number_nxt = num_c;
            else if (rx.code == SC_BKSP) letter_nxt = '0;
            else if (|let_c)             letter_nxt = let_c;
          end
          STAGE_CONFIRM: begin
            if (rx.code == SC_ENTER)     kbd_nxt    = 1'b1;
            else if (rx.code == SC_BKSP) number_nxt = '0;
            else if (|num_c)             number_nxt = num_c;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_coord_entry.sv
// Self-checking bench for ps2_coord_entry: directed PS/2 frames against an index-based
// entry model, checked every settled cycle, plus literal expectations from the test plan.
module tb_ps2_coord_entry;

  logic       clock27 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] letter, number;
  logic       keyboard_data, frame_err;
  logic [1:0] entry_stage;

  int vectors = 0;
  int miscompares = 0;

  ps2_coord_entry dut (
    .clock27      (clock27),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .letter       (letter),
    .number       (number),
    .keyboard_data(keyboard_data),
    .entry_stage  (entry_stage),
    .frame_err    (frame_err)
  );

  always #5 clock27 = ~clock27;

  // Model state: coordinates held as indices 0 (empty) or 1..9.
  byte unsigned letter_codes[9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  byte unsigned number_codes[9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int   m_l = 0, m_n = 0, m_stage = 0, c_l = 0, c_n = 0;
  bit   m_ext = 0, m_brk = 0;
  int   exp_kbd = 0, exp_err = 0, kbd_seen = 0, err_seen = 0;
  bit   settled = 0, kbd_prev = 0, err_prev = 0;
  logic [8:0] last_l = '0, last_n = '0;

  function automatic logic [8:0] oh(input int idx);
    logic [8:0] one;
    one = 9'd1;
    return (idx == 0) ? 9'd0 : (one << (idx - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input byte unsigned b);
    int li, ni;
    li = -1; ni = -1;
    for (int i = 0; i < 9; i++) begin
      if (letter_codes[i] == b) li = i;
      if (number_codes[i] == b) ni = i;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_ext || m_brk) begin m_ext = 0; m_brk = 0; end
    else if (b == 8'h76) begin m_l = 0; m_n = 0; m_stage = 0; end
    else if (m_stage == 0) begin
      if (li >= 0) begin m_l = li + 1; m_stage = 1; end
    end else if (m_stage == 1) begin
      if (ni >= 0) begin m_n = ni + 1; m_stage = 2; end
      else if (b == 8'h66) begin m_l = 0; m_stage = 0; end
      else if (li >= 0) m_l = li + 1;
    end else begin
      if (b == 8'h5A) begin
        c_l = m_l; c_n = m_n; exp_kbd++;
        m_l = 0; m_n = 0; m_stage = 0;
      end else if (b == 8'h66) begin m_n = 0; m_stage = 1; end
      else if (ni >= 0) m_n = ni + 1;
    end
  endtask

  // Per-cycle compare of outputs against the model and strobe bookkeeping.
  always @(negedge clock27) begin
    if (reset_n) begin
      if (keyboard_data) begin
        kbd_seen++;
        last_l = letter; last_n = number;
        chk("strobe_letter", 32'(letter), 32'(oh(c_l)));
        chk("strobe_number", 32'(number), 32'(oh(c_n)));
        chk("strobe_width", 32'(kbd_prev), 32'd0);
      end
      if (frame_err) begin
        err_seen++;
        chk("err_width", 32'(err_prev), 32'd0);
      end
      if (settled) begin
        chk("letter", 32'(letter), 32'(oh(m_l)));
        chk("number", 32'(number), 32'(oh(m_n)));
        chk("stage", 32'(entry_stage), 32'(m_stage));
      end
    end
    kbd_prev = keyboard_data;
    err_prev = frame_err;
  end

  function automatic logic [10:0] mkframe(input byte unsigned b, input bit bad);
    logic par;
    par = ~(^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic v);
    @(negedge clock27); ps2_data = v;
    repeat (10) @(negedge clock27);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clock27);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clock27);
  endtask

  task automatic send(input byte unsigned b, input bit bad = 0);
    logic [10:0] f;
    f = mkframe(b, bad);
    settled = 0;
    if (bad) exp_err++;
    else model_byte(b);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    repeat (20) @(negedge clock27);
    settled = 1;
    chk("kbd_count", 32'(kbd_seen), 32'(exp_kbd));
    chk("err_count", 32'(err_seen), 32'(exp_err));
  endtask

  initial begin
    // Reset and idle
    repeat (5) @(negedge clock27);
    chk("rst_letter", 32'(letter), 32'd0);
    chk("rst_number", 32'(number), 32'd0);
    chk("rst_stage", 32'(entry_stage), 32'd0);
    chk("rst_kbd", 32'(keyboard_data), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    settled = 1;
    repeat (1000) @(negedge clock27);
    chk("idle_kbd", 32'(kbd_seen), 32'd0);
    chk("idle_err", 32'(err_seen), 32'd0);

    // C, break C, 5, break 5, Enter
    send(8'h21);
    chk("lit_C", 32'(letter), 32'(9'b000000100));
    chk("lit_stage1", 32'(entry_stage), 32'd1);
    send(8'hF0); send(8'h21);
    chk("lit_C_brk", 32'(letter), 32'(9'b000000100));
    send(8'h2E);
    chk("lit_5", 32'(number), 32'(9'b000010000));
    chk("lit_stage2", 32'(entry_stage), 32'd2);
    send(8'hF0); send(8'h2E);
    send(8'h5A);
    chk("lit_commit1", 32'(kbd_seen), 32'd1);
    chk("lit_commit1_l", 32'(last_l), 32'(9'b000000100));
    chk("lit_commit1_n", 32'(last_n), 32'(9'b000010000));
    chk("lit_clear_l", 32'(letter), 32'd0);
    chk("lit_clear_n", 32'(number), 32'd0);
    chk("lit_clear_s", 32'(entry_stage), 32'd0);

    // Bad parity frame
    send(8'h1C, 1);
    chk("lit_par_err", 32'(err_seen), 32'd1);
    chk("lit_par_l", 32'(letter), 32'd0);

    // A 1 Backspace 7 Enter
    send(8'h1C); send(8'h16); send(8'h66);
    chk("lit_bksp_n", 32'(number), 32'd0);
    chk("lit_bksp_s", 32'(entry_stage), 32'd1);
    send(8'h3D); send(8'h5A);
    chk("lit_commit2_l", 32'(last_l), 32'(9'b000000001));
    chk("lit_commit2_n", 32'(last_n), 32'(9'b001000000));

    // Partial frame then timeout, then I
    begin
      logic [10:0] f;
      f = mkframe(8'h43, 0);
      for (int i = 0; i < 5; i++) ps2_bit(f[i]);
      exp_err++;
      repeat (27010) @(negedge clock27);
      chk("lit_timeout_err", 32'(err_seen), 32'd2);
    end
    send(8'h43);
    chk("lit_I", 32'(letter), 32'(9'b100000000));
    send(8'h76);

    // B, keypad Enter, Esc
    send(8'h32);
    chk("lit_B", 32'(letter), 32'(9'b000000010));
    send(8'hE0); send(8'h5A);
    chk("lit_kp_enter", 32'(letter), 32'(9'b000000010));
    send(8'h76);
    chk("lit_esc_l", 32'(letter), 32'd0);
    chk("lit_esc_s", 32'(entry_stage), 32'd0);

    // Reset mid-frame
    send(8'h1C);
    chk("lit_A", 32'(letter), 32'(9'b000000001));
    settled = 0;
    begin
      logic [10:0] f;
      f = mkframe(8'h24, 0);
      for (int i = 0; i < 4; i++) ps2_bit(f[i]);
      @(negedge clock27); ps2_data = f[4];
      repeat (10) @(negedge clock27);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clock27);
    end
    #3 reset_n = 1'b0;
    #1;
    chk("arst_letter", 32'(letter), 32'd0);
    chk("arst_number", 32'(number), 32'd0);
    chk("arst_stage", 32'(entry_stage), 32'd0);
    chk("arst_err", 32'(frame_err), 32'd0);
    m_l = 0; m_n = 0; m_stage = 0; m_ext = 0; m_brk = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (10) @(negedge clock27);
    reset_n = 1'b1;
    settled = 1;
    repeat (1000) @(negedge clock27);
    chk("arst_no_err", 32'(err_seen), 32'(exp_err));
    send(8'h24);
    chk("lit_E", 32'(letter), 32'(9'b000010000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_coord_entry.md
Name: ps2_coord_entry

Overview:
- Upstream keyboard front end for the two-player grid game.
- Receives raw PS/2 frames from the keyboard and decodes set-2 make codes into a one-hot grid coordinate: letter A–I and number 1–9.
- Drives the letter, number and keyboard-data inputs of the hex display controller.
- Commits a coordinate only when Enter is pressed. Supports Backspace and Esc editing.

Parameters:
- TIMEOUT_CYCLES, 27000: clock27 cycles of PS/2 clock inactivity that abort a partial frame (1 ms at 27 MHz).
- SYNC_STAGES, 2: flip-flop depth of the ps2_clk/ps2_data synchronisers (minimum 2).

Ports:
- clock27  input  1  system clock, 27 MHz.
- reset_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- letter  output  9  one-hot column; bit0=A … bit8=I; all-zero when empty.
- number  output  9  one-hot row; bit0=1 … bit8=9; all-zero when empty.
- keyboard_data  output  1  one-cycle strobe: coordinate committed.
- entry_stage  output  2  0=awaiting letter, 1=awaiting number, 2=awaiting Enter.
- frame_err  output  1  one-cycle strobe: frame discarded (bad start, parity, stop or timeout).

Behaviour:
- Reset (async, reset_n=0):
  - letter=0, number=0, keyboard_data=0, frame_err=0, entry_stage=0.
  - Synchroniser flops=1, bit counter=0, break/extended flags clear.
- Receiver:
  - Synchronise both lines through SYNC_STAGES flops.
  - A falling edge is synced clk 1→0 across consecutive cycles. On each falling edge, sample synced data into an 11-bit shift register, LSB first, and increment the bit count 0..10.
  - At the 11th bit, check start=0, odd parity over data+parity, and stop=1:
    - Pass → byte_valid one cycle, next cycle after the stop-bit edge.
    - Fail → frame_err pulse, byte dropped.
  - Counter clears after every frame.
- Timeout:
  - Idle counter resets on every falling edge and counts only while bit count ≠0.
  - Reaching TIMEOUT_CYCLES clears the bit count and pulses frame_err.
  - The idle count is never compared when an edge occurs in that cycle, so the edge wins.
- Decoder (acts on byte_valid, same-cycle registered update):
  - 0xE0 sets ext_pending; 0xF0 sets brk_pending; neither changes state.
  - Any other byte with either flag set is ignored and clears both flags. This covers break codes and all extended keys, including keypad Enter E0 5A.
  - Letter codes A=1C, B=32, C=21, D=23, E=24, F=2B, G=34, H=33, I=43.
  - Number codes 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46.
  - Editing codes Enter=5A, Backspace=66, Esc=76.
- FSM transitions:
  - LETTER: letter code → latch letter, go NUMBER. Backspace ignored. Other codes ignored.
  - NUMBER: number code → latch number, go CONFIRM. Backspace → letter=0, go LETTER. Letter code → replace letter, stay.
  - CONFIRM:
    - Enter → keyboard_data=1 for exactly one cycle, then letter=0, number=0, go LETTER. letter/number remain valid during the strobe cycle and clear the cycle after.
    - Backspace → number=0, go NUMBER.
    - Number code → replace number, stay.
  - Esc in any state → clear both, go LETTER.
- Repeats: typematic repeats re-present make codes and are handled as fresh presses; no debounce.
- Reset mid-frame: partial frame is lost, and no frame_err is emitted for it.
- Mid-frame desync: if the bit count is mid-frame at power-up, the timeout recovers it.

Decomposition:
- Package ps2_game_pkg:
  - Scan-code localparams (letters, digits, 5A, 66, 76, E0, F0).
  - Stage encodings LETTER=2'd0, NUMBER=2'd1, CONFIRM=2'd2.
  - Grid size constant 9.
- Sub-module ps2_rx:
  - Contains the synchronisers, edge detect, shift register, parity/timeout check, and byte_valid/byte/frame_err outputs.
  - The top level holds the decode FSM.

Test Plan:
- Reset released, no traffic for 1000 cycles → letter=0, number=0, entry_stage=0, no strobes.
- Valid frames 21, F0 21, 2E, F0 2E, 5A:
  - After 21 → letter=9'b000000100.
  - After 2E → number=9'b000010000, entry_stage=2.
  - After 5A → keyboard_data high exactly 1 cycle, then letter=0, number=0, entry_stage=0.
- Frame 1C with even parity → frame_err pulse, letter stays 0, entry_stage=0.
- Frames 1C 16 66 3D 5A → number cleared by 66, commit with letter=bit0, number=bit6 (7).
- 5 bits of a frame, idle 27001 cycles, then full 43 → one frame_err, then letter=bit8.
- Frames 32, E0 5A (keypad Enter), 76 → letter=bit1, keypad Enter ignored, Esc clears to 0. reset_n pulsed low mid-frame → all outputs 0 asynchronously, no frame_err.
